// File: rtl/exec_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// exec_hazard_ctrl_if
// Decode fields, redirect and memory-busy inputs plus stall/flush/forward
// outputs of the execute-stage hazard controller.
// Rev 1.0
// ============================================================================
interface exec_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             idValid;
  logic [4:0]       idRs1;
  logic [4:0]       idRs2;
  logic             idUsesRs1;
  logic             idUsesRs2;
  logic [4:0]       idRd;
  logic             idRegWrite;
  logic [1:0]       idMemOp;
  logic             pcSel;
  logic             dmemBusy;
  logic             stallIf;
  logic             stallId;
  logic             stallEx;
  logic             flushId;
  logic             flushEx;
  logic [1:0]       fwdA;
  logic [1:0]       fwdB;
  logic [CNT_W-1:0] stallCount;

  modport master (
    output idValid, idRs1, idRs2, idUsesRs1, idUsesRs2, idRd, idRegWrite,
           idMemOp, pcSel, dmemBusy,
    input  stallIf, stallId, stallEx, flushId, flushEx, fwdA, fwdB, stallCount
  );

  modport slave (
    input  idValid, idRs1, idRs2, idUsesRs1, idUsesRs2, idRd, idRegWrite,
           idMemOp, pcSel, dmemBusy,
    output stallIf, stallId, stallEx, flushId, flushEx, fwdA, fwdB, stallCount
  );
endinterface
`default_nettype wire

// File: rtl/exec_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// exec_hazard_ctrl
// Stall/flush sequencing and EX operand forwarding driven by a shadow
// EX/MEM/WB destination pipeline.
// Rev 1.0
// ============================================================================
module exec_hazard_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  exec_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       is_load;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } shadow_t;

  localparam logic [1:0] c_LD_INIT = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

  state_t           r_state;
  state_t           r_saved_state;
  logic [1:0]       r_cnt;
  shadow_t          r_ex;
  shadow_t          r_mem;
  shadow_t          r_wb;
  logic [CNT_W-1:0] r_stall_count;

  state_t     w_eff_state;
  state_t     w_next_state;
  state_t     w_next_saved;
  logic [1:0] w_next_cnt;
  logic       w_load_use;
  logic       w_stall_if;
  logic       w_stall_id;
  logic       w_stall_ex;
  logic       w_flush_id;
  logic       w_flush_ex;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  shadow_t    w_id_entry;

  // MEM never forwards a load: its data is not ready until WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input shadow_t mem_e,
                                         input shadow_t wb_e);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_e.valid && mem_e.reg_write && !mem_e.is_load && mem_e.rd != 5'd0 && mem_e.rd == rs)
      sel = 2'b01;
    else if (wb_e.valid && wb_e.reg_write && wb_e.rd != 5'd0 && wb_e.rd == rs)
      sel = 2'b10;
    return sel;
  endfunction

  assign w_load_use = r_ex.is_load && r_ex.reg_write && (r_ex.rd != 5'd0) && hz.idValid &&
                      ((hz.idUsesRs1 && hz.idRs1 == r_ex.rd) ||
                       (hz.idUsesRs2 && hz.idRs2 == r_ex.rd));

  // A freeze returns to the interrupted state in the same cycle it releases.
  assign w_eff_state = (r_state == ST_MEMWAIT) ? r_saved_state : r_state;

  always_comb begin
    w_stall_if   = 1'b0;
    w_stall_id   = 1'b0;
    w_stall_ex   = 1'b0;
    w_flush_id   = 1'b0;
    w_flush_ex   = 1'b0;
    w_next_state = w_eff_state;
    w_next_saved = r_saved_state;
    w_next_cnt   = r_cnt;
    if (reset) begin
      w_next_state = ST_RUN;
    end else if (hz.dmemBusy) begin
      w_stall_if   = 1'b1;
      w_stall_id   = 1'b1;
      w_stall_ex   = 1'b1;
      w_next_state = ST_MEMWAIT;
      if (r_state != ST_MEMWAIT) w_next_saved = r_state;
    end else if (hz.pcSel) begin
      w_flush_id   = 1'b1;
      w_flush_ex   = 1'b1;
      w_next_state = ST_RUN;
    end else begin
      case (w_eff_state)
        ST_LDSTALL: begin
          w_stall_if = 1'b1;
          w_stall_id = 1'b1;
          w_flush_ex = 1'b1;
          if (r_cnt == 2'd0) w_next_state = ST_RUN;
          else               w_next_cnt   = r_cnt - 2'd1;
        end
        default: begin
          w_next_state = ST_RUN;
          if (w_load_use) begin
            w_stall_if = 1'b1;
            w_stall_id = 1'b1;
            w_flush_ex = 1'b1;
            if (LOAD_LAT > 1) begin
              w_next_state = ST_LDSTALL;
              w_next_cnt   = c_LD_INIT;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (!reset && r_ex.valid) begin
      w_fwd_a = fwd_sel(r_ex.rs1, r_mem, r_wb);
      w_fwd_b = fwd_sel(r_ex.rs2, r_mem, r_wb);
    end
  end

  always_comb begin
    w_id_entry           = '0;
    w_id_entry.valid     = 1'b1;
    w_id_entry.rd        = hz.idRd;
    w_id_entry.reg_write = hz.idRegWrite;
    w_id_entry.is_load   = (hz.idMemOp == 2'b01);
    w_id_entry.rs1       = hz.idRs1;
    w_id_entry.rs2       = hz.idRs2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_saved_state <= ST_RUN;
      r_cnt         <= 2'd0;
    end else begin
      r_state       <= w_next_state;
      r_saved_state <= w_next_saved;
      r_cnt         <= w_next_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!w_stall_ex) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= (hz.idValid && !w_flush_ex && !w_stall_id) ? w_id_entry : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_stall_count <= '0;
    else if (w_stall_if && r_stall_count != {CNT_W{1'b1}})
      r_stall_count <= r_stall_count + 1'b1;
  end

  assign hz.stallIf    = w_stall_if;
  assign hz.stallId    = w_stall_id;
  assign hz.stallEx    = w_stall_ex;
  assign hz.flushId    = w_flush_id;
  assign hz.flushEx    = w_flush_ex;
  assign hz.fwdA       = w_fwd_a;
  assign hz.fwdB       = w_fwd_b;
  assign hz.stallCount = reset ? '0 : r_stall_count;

  logic w_unused;
  assign w_unused = ^{r_mem.rs1, r_mem.rs2, r_wb.rs1, r_wb.rs2, r_wb.is_load};

endmodule
`default_nettype wire

// File: tb/tb_exec_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_exec_hazard_ctrl
// Scoreboard bench: LOAD_LAT=1 and LOAD_LAT=3 (3-bit counter) instances.
// Rev 1.0
// ============================================================================
module tb_exec_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic [1:0] mop;
    logic       pc;
    logic       busy;
  } stim_t;

  typedef struct packed {
    logic        sif;
    logic        sid;
    logic        sex;
    logic        fid;
    logic        fex;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] cnt;
  } exp_t;

  logic  clk = 1'b0;
  always #5 clk = ~clk;

  stim_t cur;
  int    sel;
  logic  rst1;
  logic  rst3;
  int    n_checks = 0;
  int    n_fail   = 0;

  exp_t  exp_q[$];
  string tag_q[$];
  int    dut_q[$];

  exec_hazard_ctrl_if #(.CNT_W(32)) hz1 ();
  exec_hazard_ctrl_if #(.CNT_W(3))  hz3 ();

  exec_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(32)) u_dut1 (.clk(clk), .reset(rst1), .hz(hz1));
  exec_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(3))  u_dut3 (.clk(clk), .reset(rst3), .hz(hz3));

  assign rst1 = (sel == 1) ? cur.rst : 1'b1;
  assign rst3 = (sel == 3) ? cur.rst : 1'b1;

  assign hz1.idValid = cur.v;     assign hz3.idValid = cur.v;
  assign hz1.idRs1 = cur.rs1;     assign hz3.idRs1 = cur.rs1;
  assign hz1.idRs2 = cur.rs2;     assign hz3.idRs2 = cur.rs2;
  assign hz1.idUsesRs1 = cur.u1;  assign hz3.idUsesRs1 = cur.u1;
  assign hz1.idUsesRs2 = cur.u2;  assign hz3.idUsesRs2 = cur.u2;
  assign hz1.idRd = cur.rd;       assign hz3.idRd = cur.rd;
  assign hz1.idRegWrite = cur.rw; assign hz3.idRegWrite = cur.rw;
  assign hz1.idMemOp = cur.mop;   assign hz3.idMemOp = cur.mop;
  assign hz1.pcSel = cur.pc;      assign hz3.pcSel = cur.pc;
  assign hz1.dmemBusy = cur.busy; assign hz3.dmemBusy = cur.busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t alu(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    stim_t s;
    s = '0;
    s.v = 1'b1; s.rd = rd; s.rs1 = a; s.rs2 = b; s.u1 = 1'b1; s.u2 = 1'b1; s.rw = 1'b1;
    return s;
  endfunction

  function automatic stim_t lw(input logic [4:0] rd, input logic [4:0] a);
    stim_t s;
    s = '0;
    s.v = 1'b1; s.rd = rd; s.rs1 = a; s.u1 = 1'b1; s.rw = 1'b1; s.mop = 2'b01;
    return s;
  endfunction

  function automatic exp_t mk(input bit sif, input bit sid, input bit sex, input bit fid,
                              input bit fex, input logic [1:0] fa, input logic [1:0] fb,
                              input int cnt);
    exp_t e;
    e.sif = sif; e.sid = sid; e.sex = sex; e.fid = fid; e.fex = fex;
    e.fa = fa; e.fb = fb; e.cnt = 32'(cnt);
    return e;
  endfunction

  // Idle, load-use bubble, busy freeze and redirect flush output patterns.
  function automatic exp_t z(input logic [1:0] fa, input logic [1:0] fb, input int c);
    return mk(0, 0, 0, 0, 0, fa, fb, c);
  endfunction
  function automatic exp_t lu(input int c);
    return mk(1, 1, 0, 0, 1, 2'b00, 2'b00, c);
  endfunction
  function automatic exp_t bz(input logic [1:0] fa, input logic [1:0] fb, input int c);
    return mk(1, 1, 1, 0, 0, fa, fb, c);
  endfunction
  function automatic exp_t fl(input logic [1:0] fa, input logic [1:0] fb, input int c);
    return mk(0, 0, 0, 1, 1, fa, fb, c);
  endfunction

  task automatic step(input int dut, input stim_t s, input exp_t e, input string tag);
    @(posedge clk);
    #1;
    sel = dut;
    cur = s;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    dut_q.push_back(dut);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  o;
      string t;
      int    d;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      d = dut_q.pop_front();
      if (d == 1)
        o = mk(hz1.stallIf, hz1.stallId, hz1.stallEx, hz1.flushId, hz1.flushEx,
               hz1.fwdA, hz1.fwdB, int'(hz1.stallCount));
      else
        o = mk(hz3.stallIf, hz3.stallId, hz3.stallEx, hz3.flushId, hz3.flushEx,
               hz3.fwdA, hz3.fwdB, int'({29'd0, hz3.stallCount}));
      check({t, ".stallIf"}, 32'(o.sif), 32'(e.sif));
      check({t, ".stallId"}, 32'(o.sid), 32'(e.sid));
      check({t, ".stallEx"}, 32'(o.sex), 32'(e.sex));
      check({t, ".flushId"}, 32'(o.fid), 32'(e.fid));
      check({t, ".flushEx"}, 32'(o.fex), 32'(e.fex));
      check({t, ".fwdA"}, 32'(o.fa), 32'(e.fa));
      check({t, ".fwdB"}, 32'(o.fb), 32'(e.fb));
      check({t, ".stallCount"}, o.cnt, e.cnt);
    end
  end

  initial begin
    stim_t s;
    sel = 1;
    cur = '0;
    cur.rst = 1'b1;
    repeat (2) @(posedge clk);

    // Outputs are forced low while reset is held, even with busy/redirect active.
    s = alu(1, 2, 3); s.rst = 1'b1; s.pc = 1'b1; s.busy = 1'b1;
    step(1, s, z(0, 0, 0), "rst_hold0");
    step(1, s, z(0, 0, 0), "rst_hold1");

    step(1, alu(1, 2, 3), z(0, 0, 0), "t1_a");
    step(1, alu(4, 5, 6), z(0, 0, 0), "t1_b");
    step(1, alu(7, 8, 9), z(0, 0, 0), "t1_c");
    step(1, nop(),        z(0, 0, 0), "t1_d");

    step(1, alu(5, 1, 2),    z(0, 0, 0), "t2_p");
    step(1, alu(6, 5, 1),    z(0, 0, 0), "t2_c");
    step(1, nop(),           z(1, 0, 0), "t2_mem");
    step(1, alu(9, 3, 4),    z(0, 0, 0), "t2_p2");
    step(1, alu(12, 13, 14), z(0, 0, 0), "t2_mid");
    step(1, alu(15, 9, 2),   z(0, 0, 0), "t2_c2");
    step(1, nop(),           z(2, 0, 0), "t2_wb");
    step(1, alu(0, 1, 2),    z(0, 0, 0), "t2_p0");
    step(1, alu(16, 0, 0),   z(0, 0, 0), "t2_c0");
    step(1, nop(),           z(0, 0, 0), "t2_x0");
    step(1, nop(),           z(0, 0, 0), "t2_gap");
    step(1, alu(20, 1, 1),   z(0, 0, 0), "t2_old");
    step(1, alu(20, 2, 2),   z(0, 0, 0), "t2_young");
    step(1, alu(21, 20, 20), z(0, 0, 0), "t2_cons");
    step(1, nop(),           z(1, 1, 0), "t2_prio");
    step(1, nop(),           z(0, 0, 0), "t2_bub");

    step(1, lw(7, 1),      z(0, 0, 0), "t3_lw");
    step(1, alu(8, 7, 7),  lu(0),      "t3_lu");
    step(1, alu(8, 7, 7),  z(0, 0, 1), "t3_rel");
    step(1, nop(),         z(2, 2, 1), "t3_fwd");
    step(1, nop(),         z(0, 0, 1), "t3_idle");

    step(1, alu(24, 1, 2), z(0, 0, 1), "t4_pre");
    s = alu(25, 3, 4); s.pc = 1'b1;
    step(1, s,              fl(0, 0, 1), "t4_flush");
    step(1, alu(26, 25, 24), z(0, 0, 1), "t4_once");
    step(1, nop(),          z(0, 2, 1),  "t4_squash");
    step(1, nop(),          z(0, 0, 1),  "t4_idle");

    step(1, lw(7, 1), z(0, 0, 1), "t5_lw");
    s = alu(8, 7, 7); s.pc = 1'b1;
    step(1, s,     fl(0, 0, 1), "t5_flush");
    step(1, nop(), z(0, 0, 1),  "t5_run");
    step(1, nop(), z(0, 0, 1),  "t5_idle");

    // Freeze in RUN with a live forward and a redirect held across the freeze.
    step(1, alu(5, 1, 2), z(0, 0, 1), "tk_p");
    step(1, alu(6, 5, 1), z(0, 0, 1), "tk_c");
    s = nop(); s.busy = 1'b1; s.pc = 1'b1;
    step(1, s, bz(1, 0, 1), "tk_busy0");
    step(1, s, bz(1, 0, 2), "tk_busy1");
    s = nop(); s.pc = 1'b1;
    step(1, s,     fl(1, 0, 3), "tk_defer");
    step(1, nop(), z(0, 0, 3),  "tk_after");

    s = nop(); s.rst = 1'b1;
    step(3, s, z(0, 0, 0), "t3b_rst");
    step(3, lw(7, 1),     z(0, 0, 0), "t3b_lw");
    step(3, alu(8, 7, 7), lu(0),      "t3b_lu");
    step(3, alu(8, 7, 7), lu(1),      "t3b_b2");
    step(3, alu(8, 7, 7), lu(2),      "t3b_b3");
    step(3, alu(8, 7, 7), z(0, 0, 3), "t3b_rel");
    step(3, nop(),        z(0, 0, 3), "t3b_ex");

    s = nop(); s.rst = 1'b1;
    step(3, s, z(0, 0, 0), "t6_rst");
    step(3, lw(7, 1),     z(0, 0, 0), "t6_lw");
    step(3, alu(8, 7, 7), lu(0),      "t6_lu");
    s = alu(8, 7, 7); s.busy = 1'b1;
    for (int i = 0; i < 4; i++) step(3, s, bz(0, 0, i + 1), "t6_busy");
    step(3, alu(8, 7, 7), lu(5),      "t6_b2");
    step(3, alu(8, 7, 7), lu(6),      "t6_b3");
    step(3, alu(8, 7, 7), z(0, 0, 7), "t6_rel");
    step(3, nop(),        z(0, 0, 7), "t6_ex");

    // Counter is saturated at 7; redirect abandons LDSTALL; reset clears a freeze.
    step(3, lw(7, 1),     z(0, 0, 7), "tm_lw");
    step(3, alu(8, 7, 7), lu(7),      "tm_sat_lu");
    s = alu(8, 7, 7); s.pc = 1'b1;
    step(3, s,            fl(0, 0, 7), "tm_abandon");
    step(3, nop(),        z(0, 0, 7),  "tm_run");
    step(3, lw(7, 1),     z(0, 0, 7),  "tm_lw2");
    step(3, alu(8, 7, 7), lu(7),       "tm_lu2");
    s = alu(8, 7, 7); s.busy = 1'b1;
    step(3, s, bz(0, 0, 7), "tm_busy_sat");
    s.pc = 1'b1; s.rst = 1'b1;
    step(3, s, z(0, 0, 0), "tm_rst");
    step(3, alu(8, 7, 7), z(0, 0, 0), "tm_clean");
    step(3, nop(),        z(0, 0, 0), "tm_empty");

    repeat (3) @(posedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
